mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide execution unit for the MIPS pipeline, directly downstream of the register file.
- Consumes the two register-file read ports (rs to OperandA, rt to OperandB) for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Asserts Busy so hazard control stalls dependent instructions until the result is written.

Parameters:
- N, 32, operand/HI/LO width; iteration count equals N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- OperandA  input  N  rs value (ReadData1); multiplicand/dividend.
- OperandB  input  N  rt value (ReadData2); multiplier/divisor.
- WriteHI  input  1  MTHI strobe.
- WriteLO  input  1  MTLO strobe.
- WriteData  input  N  MTHI/MTLO data (rs).
- Busy  output  1  operation in flight; stall request.
- Done  output  1  one-cycle pulse; HI/LO are valid during this cycle.
- HI  output  N  HI register (MFHI source).
- LO  output  N  LO register (MFLO source).

Behaviour:
- Reset (asynchronous, reset==0): state=IDLE, HI=0, LO=0, Busy=0, Done=0, iteration counter=0, all internal datapath registers=0.
- FSM states: IDLE, CALC, FIN.
- IDLE with Start=1 at edge k:
  - latch Op and operand magnitudes; signed ops take the absolute value of negative operands.
  - record result signs; counter=0; go to CALC.
- CALC: one iteration per edge, edges k+1..k+N.
  - Multiply: shift-add over a 2N-bit product register.
  - Divide: restoring shift-subtract; produces quotient and remainder.
  - At the edge where counter reaches N-1, go to FIN.
- FIN, edge k+N+1:
  - apply sign fix-up; write HI/LO; Done=1 for one cycle; go to IDLE.
- Busy=1 exactly when state is CALC or FIN, i.e. N+1 cycles after the launch edge.
- A new Start in the Done cycle is accepted (state is IDLE).
- Results:
  - MULT/MULTU: {HI,LO} = full 2N-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient sign = signA^signB; remainder sign = signA (truncating division).
  - Signed overflow: -2^31 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero: fixed latency; LO=0xFFFFFFFF, HI=original OperandA, for both DIV and DIVU.
- Start while Busy: ignored; no queueing.
- MTHI/MTLO:
  - In IDLE, WriteHI/WriteLO loads WriteData into HI/LO at the edge; both strobes together load both registers.
  - Ignored while Busy.
  - Start and a write strobe in the same IDLE cycle: Start wins and the write is dropped.
- HI/LO hold their values at all times except the FIN write or an IDLE MT write; they never show partial results.
- Reset mid-operation: immediate abort to reset values; no Done pulse.
- Op=DIV/DIVU with Start=0: no effect.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, Start at edge k -> Busy high for 33 cycles; Done at edge k+33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234 after 33 cycles.
- MTHI 0xA5A5A5A5 in IDLE -> HI=0xA5A5A5A5 next cycle. MTLO while Busy -> LO unchanged. Start+WriteLO together -> write dropped, result written.
- Second Start mid-CALC with different operands -> ignored; first result is correct. Start in Done cycle -> accepted; second Done exactly 34 edges after the first launch+33.
- reset low at iteration 10 -> Busy=0, HI=LO=0, no Done. Release, then MULTU 6x7 -> LO=42, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// It uses one shift-add or restoring shift-subtract step per cycle on magnitudes, then applies a sign fix-up.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] OperandA,
  input  logic [N-1:0] OperandB,
  input  logic         WriteHI,
  input  logic         WriteLO,
  input  logic [N-1:0] WriteData,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  state_e         state_q, state_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;          // product / quotient sign
  logic           neg_rem_q, neg_rem_d;  // remainder follows the dividend
  logic           div_zero_q, div_zero_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;          // {partial product | remainder, multiplier | quotient}
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  // Operand conditioning: MULT and DIV (Op[0]==0) are the signed forms.
  logic         sign_a, sign_b;
  logic [N-1:0] mag_a, mag_b;

  assign sign_a = ~Op[0] & OperandA[N-1];
  assign sign_b = ~Op[0] & OperandB[N-1];
  assign mag_a  = sign_a ? (~OperandA + 1'b1) : OperandA;
  assign mag_b  = sign_b ? (~OperandB + 1'b1) : OperandB;

  // One shift-add multiply step.
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[N-1:1]};

  // One restoring divide step; the partial remainder is always below the divisor,
  // so the subtraction result fits in N bits whenever it is kept.
  logic [N:0]     div_shift;
  logic           div_fits;
  logic [N-1:0]   div_sub;
  logic [2*N-1:0] div_next;

  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_fits  = div_shift >= {1'b0, opb_q};
  assign div_sub   = div_shift[N-1:0] - opb_q;
  assign div_next  = div_fits ? {div_sub, acc_q[N-2:0], 1'b1}
                              : {div_shift[N-1:0], acc_q[N-2:0], 1'b0};

  // Sign fix-up of the finished magnitudes.
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = div_zero_q ? '1
                  : (neg_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0]);
  assign rem_fix  = neg_rem_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          is_div_d   = Op[1];
          neg_d      = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = Op[1] & (OperandB == '0);
          acc_d      = {{N{1'b0}}, mag_a};
          opb_d      = mag_b;
          cnt_d      = '0;
          state_d    = CALC;
        end else begin
          // A launch takes priority, so MT writes only land on cycles without Start.
          if (WriteHI) hi_d = WriteData;
          if (WriteLO) lo_d = WriteData;
        end
      end

      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = FIN;
      end

      FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign Busy = (state_q == CALC) || (state_q == FIN);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
